// File: rtl/vend_pkg.sv
// Shared types and constants for the vending sequencer.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DROP   = 2'd1,
        ST_CHANGE = 2'd2
    } vend_state_e;

    localparam logic [7:0] COIN_5  = 8'd5;
    localparam logic [7:0] COIN_10 = 8'd10;
    localparam logic [7:0] COIN_50 = 8'd50;

    localparam int unsigned DEF_PRICE_TEA    = 10;
    localparam int unsigned DEF_PRICE_COKE   = 15;
    localparam int unsigned DEF_PRICE_SPRITE = 20;
    localparam logic [7:0]  DEF_MAX_CREDIT   = 8'd250;

    // Largest hopper coin that fits in the given credit, zero if none fits.
    function automatic logic [7:0] change_coin(input logic [7:0] credit);
        if (credit >= COIN_50)      return COIN_50;
        else if (credit >= COIN_10) return COIN_10;
        else if (credit >= COIN_5)  return COIN_5;
        else                        return 8'd0;
    endfunction

endpackage

// File: rtl/vend_if.sv
// Front-panel / hopper / display bundle of the vending sequencer.
interface vend_if;
    logic       money_5, money_10, money_50;
    logic       tea, coke, sprite, cancel;
    logic       hopper_ready;
    logic [7:0] credit;
    logic       drop_tea, drop_coke, drop_sprite;
    logic       coin_out_5, coin_out_10, coin_out_50;
    logic       coin_reject, deny;
    logic [1:0] state;

    modport master (
        output money_5, money_10, money_50, tea, coke, sprite, cancel, hopper_ready,
        input  credit, drop_tea, drop_coke, drop_sprite,
               coin_out_5, coin_out_10, coin_out_50, coin_reject, deny, state
    );

    modport slave (
        input  money_5, money_10, money_50, tea, coke, sprite, cancel, hopper_ready,
        output credit, drop_tea, drop_coke, drop_sprite,
               coin_out_5, coin_out_10, coin_out_50, coin_reject, deny, state
    );
endinterface

// File: rtl/vend_edge_det.sv
// Registered falling-edge detector for active-low strobes; history resets to
// "pressed" so a button held through reset produces no event.
module vend_edge_det #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_n_i,
    output logic [WIDTH-1:0] evt_o
);
    logic [WIDTH-1:0] hist_q;
    logic [WIDTH-1:0] evt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            evt_q  <= '0;
        end else begin
            hist_q <= in_n_i;
            evt_q  <= hist_q & ~in_n_i;
        end
    end

    assign evt_o = evt_q;
endmodule

// File: rtl/vend_sequencer.sv
// Vending transaction sequencer: credit accumulate, drop, change payout.
// Build option VEND_KEEP_CREDIT_EN: keep leftover credit after a drop.
//
// state  | meaning
// IDLE   | accept coins and selections
// DROP   | one-cycle drop pulse of the selected drink
// CHANGE | pay credit out through the hopper, largest coin first
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int unsigned PRICE_TEA    = DEF_PRICE_TEA,
    parameter int unsigned PRICE_COKE   = DEF_PRICE_COKE,
    parameter int unsigned PRICE_SPRITE = DEF_PRICE_SPRITE,
    parameter logic [7:0]  MAX_CREDIT   = DEF_MAX_CREDIT
) (
    input logic   clk,
    input logic   rst_n,
    vend_if.slave vend
);
    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_DROP   = ST_DROP;
    localparam logic [1:0] S_CHANGE = ST_CHANGE;

    localparam logic [7:0] P_TEA    = 8'(PRICE_TEA);
    localparam logic [7:0] P_COKE   = 8'(PRICE_COKE);
    localparam logic [7:0] P_SPRITE = 8'(PRICE_SPRITE);

    logic [6:0] raw_n, evt;
    logic [1:0] state_q, state_d;
    logic [7:0] credit_q, credit_d, credit_c;
    logic [7:0] coin_val, change_val;
    logic [8:0] sum;
    logic       multi_coin;
    logic       drop_tea_q, drop_tea_d, drop_coke_q, drop_coke_d, drop_sprite_q, drop_sprite_d;
    logic       reject_q, reject_d, deny_q, deny_d;

    assign raw_n = {vend.cancel, vend.tea, vend.coke, vend.sprite,
                    vend.money_50, vend.money_10, vend.money_5};

    vend_edge_det #(.WIDTH(7)) u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_n_i (raw_n),
        .evt_o  (evt)
    );

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        credit_c      = credit_q;
        drop_tea_d    = 1'b0;
        drop_coke_d   = 1'b0;
        drop_sprite_d = 1'b0;
        reject_d      = 1'b0;
        deny_d        = 1'b0;
        coin_val      = evt[2] ? COIN_50 : evt[1] ? COIN_10 : evt[0] ? COIN_5 : 8'd0;
        multi_coin    = (evt[2] && (evt[1] || evt[0])) || (evt[1] && evt[0]);
        sum           = {1'b0, credit_q} + {1'b0, coin_val};
        change_val    = change_coin(credit_q);

        case (state_q)
            S_IDLE: begin
                // Coin is booked first so a same-cycle selection sees it.
                if (|evt[2:0]) begin
                    if (sum > {1'b0, MAX_CREDIT}) reject_d = 1'b1;
                    else                          credit_c = sum[7:0];
                    if (multi_coin) reject_d = 1'b1;
                end
                if (evt[6]) begin
                    if (credit_c != 8'd0) state_d = S_CHANGE;
                end else if (evt[5]) begin
                    if (credit_c >= P_TEA) begin
                        credit_c   = credit_c - P_TEA;
                        drop_tea_d = 1'b1;
                        state_d    = S_DROP;
                    end else deny_d = 1'b1;
                end else if (evt[4]) begin
                    if (credit_c >= P_COKE) begin
                        credit_c    = credit_c - P_COKE;
                        drop_coke_d = 1'b1;
                        state_d     = S_DROP;
                    end else deny_d = 1'b1;
                end else if (evt[3]) begin
                    if (credit_c >= P_SPRITE) begin
                        credit_c      = credit_c - P_SPRITE;
                        drop_sprite_d = 1'b1;
                        state_d       = S_DROP;
                    end else deny_d = 1'b1;
                end
                credit_d = credit_c;
            end
            S_DROP: begin
                reject_d = |evt[2:0];
`ifdef VEND_KEEP_CREDIT_EN
                state_d = S_IDLE;
`else
                state_d = (credit_q != 8'd0) ? S_CHANGE : S_IDLE;
`endif
            end
            S_CHANGE: begin
                reject_d = |evt[2:0];
                if (vend.hopper_ready && change_val != 8'd0) credit_d = credit_q - change_val;
                if (credit_d == 8'd0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            credit_q      <= 8'd0;
            drop_tea_q    <= 1'b0;
            drop_coke_q   <= 1'b0;
            drop_sprite_q <= 1'b0;
            reject_q      <= 1'b0;
            deny_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            drop_tea_q    <= drop_tea_d;
            drop_coke_q   <= drop_coke_d;
            drop_sprite_q <= drop_sprite_d;
            reject_q      <= reject_d;
            deny_q        <= deny_d;
        end
    end

    assign vend.credit      = credit_q;
    assign vend.state       = state_q;
    assign vend.drop_tea    = drop_tea_q;
    assign vend.drop_coke   = drop_coke_q;
    assign vend.drop_sprite = drop_sprite_q;
    assign vend.coin_reject = reject_q;
    assign vend.deny        = deny_q;
    assign vend.coin_out_5  = (state_q == S_CHANGE) && (change_val == COIN_5);
    assign vend.coin_out_10 = (state_q == S_CHANGE) && (change_val == COIN_10);
    assign vend.coin_out_50 = (state_q == S_CHANGE) && (change_val == COIN_50);
endmodule

// File: tb/tb_vend_sequencer.sv
// Directed self-checking bench for vend_sequencer.
module tb_vend_sequencer;
    logic clk;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    vend_if vif ();

    vend_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vend  (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // press mask bits: 6 cancel, 5 tea, 4 coke, 3 sprite, 2 m50, 1 m10, 0 m5
    typedef struct {
        logic [6:0] press;
        logic [7:0] credit;
        logic [1:0] state;
        logic [2:0] drops;   // {tea, coke, sprite}
        logic       reject;
        logic       deny;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_mask(input logic [6:0] m);
        vif.cancel   = ~m[6];
        vif.tea      = ~m[5];
        vif.coke     = ~m[4];
        vif.sprite   = ~m[3];
        vif.money_50 = ~m[2];
        vif.money_10 = ~m[1];
        vif.money_5  = ~m[0];
    endtask

    // Called at a negedge; returns at the negedge where the effect is visible.
    task automatic press(input logic [6:0] m);
        set_mask(m);
        @(negedge clk);
        set_mask(7'd0);
        @(negedge clk);
    endtask

    task automatic drain(input string nm, input int e5, input int e10, input int e50);
        int n5 = 0, n10 = 0, n50 = 0, cyc = 0;
        vif.hopper_ready = 1'b1;
        while (vif.state != 2'd0 && cyc < 300) begin
            if (vif.coin_out_5)  n5++;
            if (vif.coin_out_10) n10++;
            if (vif.coin_out_50) n50++;
            @(negedge clk);
            cyc++;
        end
        chk({nm, " n5"}, n5, e5);
        chk({nm, " n10"}, n10, e10);
        chk({nm, " n50"}, n50, e50);
        chk({nm, " end credit"}, vif.credit, 0);
        chk({nm, " end state"}, vif.state, 0);
        vif.hopper_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{7'b1000000, 8'd0,   2'd0, 3'b000, 1'b0, 1'b0}; // cancel at 0
        vecs[1] = '{7'b0100000, 8'd0,   2'd0, 3'b000, 1'b0, 1'b1}; // tea, no credit
        vecs[2] = '{7'b0000001, 8'd5,   2'd0, 3'b000, 1'b0, 1'b0};
        vecs[3] = '{7'b0100001, 8'd0,   2'd1, 3'b100, 1'b0, 1'b0}; // coin then tea
        vecs[4] = '{7'b0000010, 8'd10,  2'd0, 3'b000, 1'b0, 1'b0};
        vecs[5] = '{7'b0001000, 8'd10,  2'd0, 3'b000, 1'b0, 1'b1};
        vecs[6] = '{7'b0010000, 8'd10,  2'd0, 3'b000, 1'b0, 1'b1};
        vecs[7] = '{7'b0000111, 8'd60,  2'd0, 3'b000, 1'b1, 1'b0}; // 50 wins
        vecs[8] = '{7'b0000100, 8'd110, 2'd0, 3'b000, 1'b0, 1'b0};

        rst_n = 1'b0;
        vif.hopper_ready = 1'b0;
        set_mask(7'b0000010);                 // money_10 held low through reset
        repeat (3) @(negedge clk);
        chk("reset credit", vif.credit, 0);
        chk("reset state", vif.state, 0);
        chk("reset outs", {vif.drop_tea, vif.drop_coke, vif.drop_sprite, vif.coin_out_5,
                           vif.coin_out_10, vif.coin_out_50, vif.coin_reject, vif.deny}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("held low no event", vif.credit, 0);
        set_mask(7'd0);
        repeat (3) @(negedge clk);
        chk("release no event", vif.credit, 0);

        for (int i = 0; i < 9; i++) begin
            press(vecs[i].press);
            chk($sformatf("vec%0d credit", i), vif.credit, vecs[i].credit);
            chk($sformatf("vec%0d state", i), vif.state, vecs[i].state);
            chk($sformatf("vec%0d drops", i), {vif.drop_tea, vif.drop_coke, vif.drop_sprite}, vecs[i].drops);
            chk($sformatf("vec%0d reject", i), vif.coin_reject, vecs[i].reject);
            chk($sformatf("vec%0d deny", i), vif.deny, vecs[i].deny);
        end

        // cancel 110 with hopper stalled, coin during CHANGE, then pay out
        press(7'b1000000);
        chk("cancel state", vif.state, 2);
        chk("cancel coin50", vif.coin_out_50, 1);
        press(7'b0000001);
        chk("change coin reject", vif.coin_reject, 1);
        chk("change coin credit", vif.credit, 110);
        drain("cancel110", 0, 1, 2);

`ifdef VEND_KEEP_CREDIT_EN
        press(7'b0000100);
        press(7'b0000010);
        press(7'b0100000);
        chk("keep tea drop", vif.drop_tea, 1);
        chk("keep tea credit", vif.credit, 50);
        @(negedge clk);
        chk("keep state", vif.state, 0);
        chk("keep credit", vif.credit, 50);
        chk("keep no coin", {vif.coin_out_5, vif.coin_out_10, vif.coin_out_50}, 0);
        press(7'b1000000);
        drain("keep cancel", 0, 0, 1);
`else
        press(7'b0000001);
        press(7'b0000010);
        chk("t1 credit", vif.credit, 15);
        press(7'b0100000);
        chk("t1 drop", vif.drop_tea, 1);
        chk("t1 credit after", vif.credit, 5);
        drain("t1", 1, 0, 0);

        press(7'b0000001);
        press(7'b0000001);
        press(7'b0000010);
        chk("t2 credit", vif.credit, 20);
        press(7'b0010000);
        chk("t2 drop", vif.drop_coke, 1);
        drain("t2", 1, 0, 0);

        press(7'b0000010);
        press(7'b0000100);
        press(7'b0001000);
        chk("t3 drop", vif.drop_sprite, 1);
        chk("t3 credit", vif.credit, 40);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("t3 stall%0d coin10", k), vif.coin_out_10, 1);
            chk($sformatf("t3 stall%0d credit", k), vif.credit, 40);
        end
        drain("t3", 0, 4, 0);
`endif

        press(7'b0000010);
        press(7'b0001000);
        chk("t4 deny", vif.deny, 1);
        chk("t4 credit", vif.credit, 10);
        press(7'b1000000);
        drain("t4", 0, 1, 0);

        for (int k = 0; k < 4; k++) press(7'b0000100);
        for (int k = 0; k < 4; k++) press(7'b0000010);
        press(7'b0000001);
        chk("t5 credit", vif.credit, 245);
        press(7'b0000010);
        chk("t5 over reject", vif.coin_reject, 1);
        chk("t5 over credit", vif.credit, 245);
        press(7'b0000001);
        chk("t5 max reject", vif.coin_reject, 0);
        chk("t5 max credit", vif.credit, 250);
        press(7'b0000001);
        chk("t5 255 reject", vif.coin_reject, 1);
        chk("t5 255 credit", vif.credit, 250);

        press(7'b1000000);
        chk("t6 state", vif.state, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("t6 async credit", vif.credit, 0);
        chk("t6 async state", vif.state, 0);
        chk("t6 async coin", {vif.coin_out_5, vif.coin_out_10, vif.coin_out_50}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
